// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolution queue.
//  br_op_e    : control-flow operation issued to a branch port
//  cf_t       : control-flow class (predicted and resolved)
//  br_entry_t : one resolution record held in the queue and shown at the head
// The entry struct is sized by BR_VLEN / BR_TID_BITS; instantiate the top with
// matching VLEN / TRANS_ID_BITS.
package branch_resolve_queue_pkg;

   localparam int unsigned BR_VLEN     = 64;
   localparam int unsigned BR_TID_BITS = 3;

   typedef enum logic [2:0] {
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
   } br_op_e;

   typedef enum logic [2:0] {
      NoCF, Branch, Jump, JumpR, Return
   } cf_t;

   typedef struct packed {
      logic [BR_VLEN-1:0]     pc;
      logic [BR_VLEN-1:0]     target;
      logic                   is_taken;
      logic                   is_mispredict;
      logic                   exc;
      cf_t                    cf_type;
      logic [BR_TID_BITS-1:0] trans_id;
   } br_entry_t;

   // Conditional branches are everything except the two jumps.
   function automatic logic is_bxx(input br_op_e op);
      return !(op == BR_JAL || op == BR_JALR);
   endfunction

endpackage

// File: rtl/branch_resolve_queue_br_target_calc.sv
// Per-port resolution logic (purely combinational).
//  i_op/i_pc/i_imm/i_opa  : operation, pc, immediate, rs1
//  i_comp                 : branch comparison result
//  i_compressed           : 16-bit instruction (link = pc+2)
//  i_pred_cf/i_pred_addr  : frontend prediction
//  o_target               : resolved next pc (jump target when taken, link otherwise)
//  o_link                 : pc+2 / pc+4
//  o_taken/o_mispredict/o_exc/o_cf : resolution flags and class
module br_target_calc
   import branch_resolve_queue_pkg::*;
#(
   parameter int unsigned VLEN = BR_VLEN,
   parameter bit          RVC  = 1'b1
) (
   input  br_op_e            i_op,
   input  logic [VLEN-1:0]   i_pc,
   input  logic [VLEN-1:0]   i_imm,
   input  logic [VLEN-1:0]   i_opa,
   input  logic              i_comp,
   input  logic              i_compressed,
   input  cf_t               i_pred_cf,
   input  logic [VLEN-1:0]   i_pred_addr,
   output logic [VLEN-1:0]   o_target,
   output logic [VLEN-1:0]   o_link,
   output logic              o_taken,
   output logic              o_mispredict,
   output logic              o_exc,
   output cf_t               o_cf
);

   logic [VLEN-1:0] w_jt;
   logic            w_mis_raw;

   always_comb begin
      o_link   = i_pc + (i_compressed ? VLEN'(2) : VLEN'(4));
      w_jt     = (i_op == BR_JALR) ? ((i_opa + i_imm) & ~VLEN'(1)) : (i_pc + i_imm);
      o_taken  = is_bxx(i_op) ? i_comp : 1'b1;
      o_cf     = is_bxx(i_op) ? Branch : ((i_op == BR_JAL) ? Jump : JumpR);
      o_target = o_taken ? w_jt : o_link;
      o_exc    = !RVC && o_taken && w_jt[1];
      case (o_cf)
         Branch:  w_mis_raw = (o_taken != (i_pred_cf == Branch)) ||
                              (o_taken && (i_pred_addr != w_jt));
         Jump:    w_mis_raw = (i_pred_cf == NoCF);
         default: w_mis_raw = (i_pred_cf == NoCF) || (i_pred_addr != w_jt);
      endcase
      // A faulting target is reported as an exception, never as a redirect.
      o_mispredict = w_mis_raw && !o_exc;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// Multi-port branch resolution unit with an in-order drain queue.
//  clk_i/rst_i/flush_i        : clock, sync active-high reset, pipeline flush
//  valid_i..pred_addr_i       : NR_PORTS branch inputs, port 0 oldest
//  ready_o                    : queue can take NR_PORTS entries this cycle
//  link_o                     : per-port pc+2/pc+4 (combinational)
//  res_valid_o/res_ready_i    : head handshake, res_o is the head entry
//  exc_valid_o/exc_tval_o     : head carries a misaligned-target exception
//  mispredict_cnt_o           : saturating count of drained mispredicts
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int unsigned VLEN          = BR_VLEN,
   parameter int unsigned NR_PORTS      = 2,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned TRANS_ID_BITS = BR_TID_BITS,
   parameter bit          RVC           = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   input  logic [NR_PORTS-1:0]                    valid_i,
   input  br_op_e                                 op_i [NR_PORTS],
   input  logic [NR_PORTS-1:0][VLEN-1:0]          pc_i,
   input  logic [NR_PORTS-1:0][VLEN-1:0]          imm_i,
   input  logic [NR_PORTS-1:0][VLEN-1:0]          operand_a_i,
   input  logic [NR_PORTS-1:0]                    comp_res_i,
   input  logic [NR_PORTS-1:0]                    is_compressed_i,
   input  logic [NR_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
   input  cf_t                                    pred_cf_i [NR_PORTS],
   input  logic [NR_PORTS-1:0][VLEN-1:0]          pred_addr_i,
   output logic                                   ready_o,
   output logic [NR_PORTS-1:0][VLEN-1:0]          link_o,
   output logic                                   res_valid_o,
   input  logic                                   res_ready_i,
   output br_entry_t                              res_o,
   output logic                                   exc_valid_o,
   output logic [VLEN-1:0]                        exc_tval_o,
   output logic [CNT_W-1:0]                       mispredict_cnt_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   br_entry_t          r_q [DEPTH];
   logic [PW-1:0]      r_rd, r_wr;
   logic [CW-1:0]      r_cnt;
   logic               r_ready;
   logic [CNT_W-1:0]   r_mis_cnt;

   br_entry_t          w_ent [NR_PORTS];
   br_entry_t          w_head;
   logic [PW-1:0]      w_slot [NR_PORTS];
   logic [NR_PORTS-1:0] w_push;
   logic [CW-1:0]      w_npush, w_cnt_nxt;
   logic               w_valid, w_pop, w_squash, w_clear;

   for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
      logic [VLEN-1:0] w_target;
      logic            w_taken, w_mis, w_exc;
      cf_t             w_cf;

      br_target_calc #(.VLEN(VLEN), .RVC(RVC)) u_calc (
         .i_op         (op_i[p]),
         .i_pc         (pc_i[p]),
         .i_imm        (imm_i[p]),
         .i_opa        (operand_a_i[p]),
         .i_comp       (comp_res_i[p]),
         .i_compressed (is_compressed_i[p]),
         .i_pred_cf    (pred_cf_i[p]),
         .i_pred_addr  (pred_addr_i[p]),
         .o_target     (w_target),
         .o_link       (link_o[p]),
         .o_taken      (w_taken),
         .o_mispredict (w_mis),
         .o_exc        (w_exc),
         .o_cf         (w_cf)
      );

      assign w_ent[p] = '{pc: pc_i[p], target: w_target, is_taken: w_taken,
                          is_mispredict: w_mis, exc: w_exc, cf_type: w_cf,
                          trans_id: trans_id_i[p]};
   end

   // Valid ports are packed: each takes the next free slot after all older valid ports.
   always_comb begin
      w_push  = valid_i & {NR_PORTS{r_ready}};
      w_npush = '0;
      for (int p = 0; p < NR_PORTS; p++) begin
         w_slot[p] = PW'((int'(r_wr) + int'(w_npush)) % DEPTH);
         if (w_push[p]) w_npush = w_npush + CW'(1);
      end
   end

   assign w_head    = r_q[r_rd];
   assign w_valid   = (r_cnt != '0);
   assign w_pop     = w_valid && res_ready_i;
   assign w_squash  = w_pop && (w_head.is_mispredict || w_head.exc);
   assign w_clear   = flush_i || w_squash;
   assign w_cnt_nxt = r_cnt + w_npush - CW'(w_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd      <= '0;
         r_wr      <= '0;
         r_cnt     <= '0;
         r_ready   <= 1'b1;
         r_mis_cnt <= '0;
      end else begin
         // A flushed pop never reaches the frontend, so it is not counted.
         if (!flush_i && w_pop && w_head.is_mispredict && (r_mis_cnt != '1))
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
         if (w_clear) begin
            // Pushes this cycle are dropped, so the write pointer stays put.
            r_rd    <= r_wr;
            r_cnt   <= '0;
            r_ready <= 1'b1;
         end else begin
            r_cnt   <= w_cnt_nxt;
            r_wr    <= PW'((int'(r_wr) + int'(w_npush)) % DEPTH);
            if (w_pop) r_rd <= PW'((int'(r_rd) + 1) % DEPTH);
            r_ready <= (int'(DEPTH) - int'(w_cnt_nxt)) >= int'(NR_PORTS);
         end
      end
   end

   // Storage needs no reset: every output view of it is gated by the count.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !w_clear) begin
         for (int p = 0; p < NR_PORTS; p++)
            if (w_push[p]) r_q[w_slot[p]] <= w_ent[p];
      end
   end

   assign ready_o          = r_ready;
   assign res_valid_o      = w_valid;
   assign res_o            = w_valid ? w_head : '0;
   assign exc_valid_o      = w_valid && w_head.exc;
   assign exc_tval_o       = exc_valid_o ? w_head.target : '0;
   assign mispredict_cnt_o = r_mis_cnt;

endmodule
